scan_display: RTL
=================

Name: scan_display

Overview:
Parametrised time-multiplexed 7-segment driver for the digital-clock display board. It scans DIGITS common-select digits, one digit per slot, from a packed hex/BCD word. Over the fixed 6-digit scanner it adds a programmable scan prescaler, frame-coherent input snapshot, per-digit decimal point, blanking and blinking, leading-zero suppression and output polarity selection. It sits between the time/alarm datapath and the board pins.

Parameters:
DIGITS, 6, number of digits scanned (2..8)
SCAN_DIV, 1000, CP cycles per digit slot (>=2)
BLINK_FRAMES, 64, full frames per blink half-period (>=1)
SEG_ACTIVE_LOW, 0, 1 inverts codeout and dp_out at the pins
SEL_ACTIVE_LOW, 0, 1 inverts seg at the pins

Ports:
CP  in  1  system clock
CR  in  1  asynchronous active-high reset
en  in  1  scan enable
data  in  4*DIGITS  digit i = data[4i+3:4i]; digit 0 is rightmost
dp  in  DIGITS  decimal point request per digit
blank_mask  in  DIGITS  1 = digit forced dark
blink_mask  in  DIGITS  1 = digit dark during blink-off phase
lz_suppress  in  1  leading-zero suppression enable
codeout  out  7  segments {g,f,e,d,c,b,a}, registered
dp_out  out  1  decimal point segment, registered
seg  out  DIGITS  one-hot digit select, registered; bit i drives digit i
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (CR high, async): prescaler=0, slot pointer p=0, started=0, frame counter=0, blink phase=on, snapshot cleared, frame_done=0. Outputs inactive: seg all-off, codeout all-off, dp_out off, after polarity mapping.
- Prescaler counts 0..SCAN_DIV-1 while en=1. tick = (count==SCAN_DIV-1). Count wraps to 0 on tick.
- On tick:
  - if started=0 or p==DIGITS-1: p<=0, snapshot<=data/dp/blank_mask/blink_mask/lz_suppress, started<=1.
  - otherwise p<=p+1.
- frame_done pulses on a tick with p==DIGITS-1 and started=1.
- Digit 0 of each frame decodes from the freshly captured values, so there is no tearing. Input changes mid-frame take effect at the next frame only.
- Outputs update on the CP edge that processes the tick: seg = one-hot(p_next), with codeout/dp_out for that digit. Latency is 1 CP from the tick. The first lit slot occurs SCAN_DIV cycles after CR release with en=1.
- Decode, hex gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Digit i is dark (codeout off, dp_out off, seg still selected) if any of these holds:
  - blank_mask[i]=1;
  - blink_mask[i]=1 and blink phase=off;
  - lz_suppress=1, i>0, and snapshot digits DIGITS-1..i are all zero. Digit 0 is never suppressed.
- Blink: the frame counter increments on each frame_done. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
- en=0: on the next CP, seg/codeout/dp_out go inactive. Prescaler, p, snapshot and blink state hold. On en=1, scanning resumes at the held count and slot.
- DIGITS<8: unused data bits are ignored.
- Polarity: an XOR with the polarity parameters is applied at the output registers, including the reset values.

Decomposition:
- Package scan_display_pkg holds:
  - 16-entry hex-to-segment constant table;
  - segment bit-index constants (SEG_A..SEG_G);
  - function clog2 for the p and frame-counter widths.
- Sub-module seg7_hex_decode: combinational 4-bit to 7-bit table lookup, instanced once on the selected snapshot digit.

Test Plan:
All scenarios use DIGITS=6, SCAN_DIV=4, BLINK_FRAMES=2, active-high polarity.
1. Release CR, en=1, data=0x123456 -> cycle 4 after release: seg=000001, codeout=7D. Every 4 cycles seg shifts left, showing 6D,66,4F,5B,06. After seg=100000, the next tick gives seg=000001 and frame_done=1 for one cycle.
2. Change data to 0x999999 while seg=000100 -> remaining slots still show 4F,5B,06. The next frame shows 6F on all digits.
3. lz_suppress=1, data=0x000120 -> digits 5,4,3 dark, digit2=06, digit1=5B, digit0=3F. data=0x000000 -> only digit0 lit with 3F.
4. blink_mask=000011, dp=000100 -> digits 0,1 lit for 2 frames, dark for 2 frames, repeating. dp_out=1 only in the digit-2 slot, every frame.
5. en=0 while seg=001000 -> next cycle seg=000000, codeout=00. en=1 after 10 cycles -> seg=001000 again, slot completes its remaining count.
6. Assert CR mid-slot, between CP edges -> seg, codeout, dp_out and frame_done go inactive immediately without a clock. After release, scenario 1 timing repeats exactly.

Source files
------------

// File: rtl/scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: the segment code table and
// the width helper used to size the slot pointer, prescaler and frame counter.
package scan_display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry n is the {g,f,e,d,c,b,a} pattern for hex digit n (entry 0 is the lowest slice).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Bits needed to count 0..n-1; never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to {g,f,e,d,c,b,a} segment pattern, active-high.
module seg7_hex_decode
  import scan_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg7
);

  assign seg7 = HEX_SEG[hex];

endmodule

// File: rtl/scan_display.sv
// Time-multiplexed 7-segment scanner: one digit per prescaler slot, inputs snapshotted at
// each frame start, with blanking, blinking, leading-zero suppression and pin polarity.
module scan_display
  import scan_display_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_suppress,
  output logic [6:0]            codeout,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     seg,
  output logic                  frame_done
);

  localparam int PW = clog2(DIGITS);
  localparam int CW = clog2(SCAN_DIV);
  localparam int FW = clog2(BLINK_FRAMES);
  localparam logic [6:0]        SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_POL = {DIGITS{SEL_ACTIVE_LOW}};

  logic [CW-1:0]       cnt;
  logic [PW-1:0]       p, p_next, idx;
  logic                started;
  logic [FW-1:0]       fcnt;
  logic                blink_on;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp, snap_blank, snap_blink;
  logic                snap_lz;

  logic                tick, last, cap, frame_end, phase;
  logic [4*DIGITS-1:0] s_data;
  logic [DIGITS-1:0]   s_dp, s_blank, s_blink, dark_vec;
  logic                s_lz, lead;
  logic [3:0]          digit;
  logic                dark, dp_sel;
  logic [6:0]          dec_seg;

  always_comb begin
    tick      = en && (cnt == CW'(SCAN_DIV - 1));
    last      = (p == PW'(DIGITS - 1));
    cap       = tick && (!started || last);
    frame_end = tick && started && last;
    p_next    = cap ? '0 : p + 1'b1;
    idx       = tick ? p_next : p;
    // The frame that starts on this tick must already see the new blink phase.
    phase     = (frame_end && (fcnt == FW'(BLINK_FRAMES - 1))) ? ~blink_on : blink_on;
    // Digit 0 decodes from the values being captured, not the stale snapshot.
    s_data    = cap ? data        : snap_data;
    s_dp      = cap ? dp          : snap_dp;
    s_blank   = cap ? blank_mask  : snap_blank;
    s_blink   = cap ? blink_mask  : snap_blink;
    s_lz      = cap ? lz_suppress : snap_lz;
  end

  always_comb begin
    lead     = 1'b1;
    dark_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead        = lead && (s_data[4*i +: 4] == 4'h0);
      dark_vec[i] = s_blank[i] | (s_blink[i] & ~phase) | (s_lz & lead & (i != 0));
    end
  end

  always_comb begin
    digit  = '0;
    dark   = 1'b0;
    dp_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == PW'(i)) begin
        digit  = s_data[4*i +: 4];
        dark   = dark_vec[i];
        dp_sel = s_dp[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .hex  (digit),
    .seg7 (dec_seg)
  );

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      cnt        <= '0;
      p          <= '0;
      started    <= 1'b0;
      fcnt       <= '0;
      blink_on   <= 1'b1;
      snap_data  <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_blink <= '0;
      snap_lz    <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      p   <= p_next;
      if (cap) begin
        started    <= 1'b1;
        snap_data  <= data;
        snap_dp    <= dp;
        snap_blank <= blank_mask;
        snap_blink <= blink_mask;
        snap_lz    <= lz_suppress;
      end
      if (frame_end) begin
        blink_on <= phase;
        fcnt     <= (fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
      end
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Outside a lit slot (disabled, or before the first tick) the pins idle inactive.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      seg        <= SEL_POL;
      codeout    <= SEG_POL;
      dp_out     <= SEG_ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (en && (tick || started)) begin
        seg     <= (DIGITS'(1) << idx) ^ SEL_POL;
        codeout <= (dark ? 7'h00 : dec_seg) ^ SEG_POL;
        dp_out  <= (dp_sel & ~dark) ^ SEG_ACTIVE_LOW;
      end else begin
        seg     <= SEL_POL;
        codeout <= SEG_POL;
        dp_out  <= SEG_ACTIVE_LOW;
      end
    end
  end

endmodule
